// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined ALU logic unit: op encodings and pipeline depth bounds.
package logic_unit_pkg;
  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND   = 3'b000;
  localparam logic [OP_W-1:0] OP_OR    = 3'b001;
  localparam logic [OP_W-1:0] OP_NAND  = 3'b010;
  localparam logic [OP_W-1:0] OP_NOR   = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR   = 3'b100;
  localparam logic [OP_W-1:0] OP_XNOR  = 3'b101;
  localparam logic [OP_W-1:0] OP_ANDN  = 3'b110;
  localparam logic [OP_W-1:0] OP_PASSA = 3'b111;

  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 4;
endpackage

// File: rtl/logic_pipe_stage.sv
// One elastic register stage: holds a valid bit plus payload and advances when empty or drained.
// Upstream derives its own ready from the chain's valid bits, so no ready is driven from here.
module logic_pipe_stage
  import logic_unit_pkg::*;
#(
  parameter int PW = 19
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [PW-1:0] in_data,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [PW-1:0] out_data
);
  logic advance;

  assign advance = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (advance) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end
endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit with valid/ready handshake and zero/parity/err flags.
// Optional LOGIC_UNIT_CNT_EN adds a 32-bit output-transfer counter on port op_count.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       alu_fun,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] logic_out,
  output logic             logic_flag,
  output logic             zero_flag,
  output logic             parity_flag,
  output logic             err_flag
`ifdef LOGIC_UNIT_CNT_EN
  ,
  output logic [31:0]      op_count
`endif
);
  // Handshake: a transfer happens on a posedge where valid & ready are both 1;
  // valid never depends on ready, and a stalled output holds its payload stable.
  localparam int PW = WIDTH + 3;

  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX || WIDTH < 2) begin : g_bad_cfg
    $error("logic_unit_pipe: unsupported WIDTH/STAGES");
  end

  logic [WIDTH-1:0]  res;
  logic [PW-1:0]     pay0;
  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] rdy;
  logic [PW-1:0]     dat [STAGES];

  always_comb begin
    res = '0;
    case (alu_fun[OP_W-1:0])
      OP_AND:   res = a & b;
      OP_OR:    res = a | b;
      OP_NAND:  res = ~(a & b);
      OP_NOR:   res = ~(a | b);
      OP_XOR:   res = a ^ b;
      OP_XNOR:  res = ~(a ^ b);
      OP_ANDN:  res = a & ~b;
      OP_PASSA: res = a;
    endcase
    if (alu_fun[3]) res = '0;
  end

  assign pay0 = {alu_fun[3], ^res, ~|res, res};

  // Stage s can advance iff some stage at or after s is empty or the sink accepts;
  // written in closed form so ready never chains through itself.
  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      rdy[s] = out_ready;
      for (int k = s; k < STAGES; k++) begin
        if (!vld[k]) rdy[s] = 1'b1;
      end
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic          st_in_valid;
    logic [PW-1:0] st_in_data;
    logic          st_out_ready;

    if (s == 0) begin : g_head
      assign st_in_valid = in_valid & ~rst;
      assign st_in_data  = pay0;
    end else begin : g_body
      assign st_in_valid = vld[s-1];
      assign st_in_data  = dat[s-1];
    end

    if (s == STAGES - 1) begin : g_tail
      assign st_out_ready = out_ready;
    end else begin : g_mid
      assign st_out_ready = rdy[s+1];
    end

    logic_pipe_stage #(.PW(PW)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (st_in_valid),
      .in_data   (st_in_data),
      .out_ready (st_out_ready),
      .out_valid (vld[s]),
      .out_data  (dat[s])
    );
  end

  assign in_ready    = rdy[0] & ~rst;
  assign out_valid   = vld[STAGES-1];
  assign logic_flag  = vld[STAGES-1];
  assign logic_out   = dat[STAGES-1][WIDTH-1:0];
  assign zero_flag   = dat[STAGES-1][WIDTH];
  assign parity_flag = dat[STAGES-1][WIDTH+1];
  assign err_flag    = dat[STAGES-1][WIDTH+2];

`ifdef LOGIC_UNIT_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else if (out_valid && out_ready) cnt_q <= cnt_q + 32'd1;
  end

  assign op_count = cnt_q;
`endif
endmodule
